// File: rtl/dnn_pkg.sv
// Shared sizes, word-index map and FSM encoding for the AXI-attached 3-12-6-1 MLP.
// Q5.10 helpers: arithmetic shift-down with 16-bit clamp, and ReLU.
package dnn_pkg;
   localparam int N_IN   = 3;
   localparam int N_H1   = 12;
   localparam int N_H2   = 6;
   localparam int N_SAMP = 16;
   localparam int FRAC   = 10;

   // Region bases as 32-bit word indices (byte address >> 2)
   localparam logic [7:0] CTRL_IDX    = 8'd0;
   localparam logic [7:0] W1_IDX      = 8'd4;
   localparam logic [7:0] W2_IDX      = 8'd52;
   localparam logic [7:0] W3_IDX      = 8'd124;
   localparam logic [7:0] W3_BIAS_IDX = 8'd130;
   localparam logic [7:0] X_IDX       = 8'd132;
   localparam logic [7:0] X_LAST_IDX  = 8'd179;
   localparam logic [7:0] Y_IDX       = 8'd132;
   localparam logic [7:0] Y_LAST_IDX  = 8'd147;
   localparam int         MEM_LO      = 4;
   localparam int         MEM_HI      = 179;

   typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_L3, S_STORE, S_DONE} state_t;

   function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
      logic signed [31:0] sh;
      sh = v >>> FRAC;
      if (sh > 32'sd32767)       return 16'sh7fff;
      else if (sh < -32'sd32768) return 16'sh8000;
      else                       return sh[15:0];
   endfunction

   function automatic logic signed [15:0] relu(input logic signed [15:0] v);
      return v[15] ? 16'sd0 : v;
   endfunction
endpackage

// File: rtl/dnn_mac.sv
// Single signed 16x16 multiply-accumulate with a 32-bit accumulator.
// 'first' restarts the sum from the bias (scaled to Q.20) instead of the old accumulator.
module dnn_mac
   import dnn_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               first,
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   input  logic signed [15:0] bias,
   output logic signed [15:0] res
);
   logic signed [31:0] acc;
   logic signed [31:0] prod;
   logic signed [31:0] base;

   assign prod = a * b;
   assign base = first ? (signed'(32'(bias)) <<< FRAC) : acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  acc <= '0;
      else if (en) acc <= base + prod;
   end

   assign res = sat16(acc);
endmodule

// File: rtl/axi_dnn_slave.sv
// AXI4-Lite slave: weight/feature storage, result readback and the sequential MLP engine.
// state   | meaning
// IDLE    | waiting for start
// L1      | hidden layer 1, neuron j, input i (3 MACs per neuron)
// L2      | hidden layer 2, neuron j, input i (12 MACs per neuron)
// L3      | output neuron, input i (6 MACs)
// STORE   | write Y[s], advance sample
// DONE    | batch finished, done flag raised
module axi_dnn_slave
   import dnn_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [31:0]       s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [DATA_W-1:0] s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [31:0]       s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [DATA_W-1:0] s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready
);
   logic [15:0]        mem [MEM_LO:MEM_HI];
   logic signed [15:0] h1 [0:N_H1-1];
   logic signed [15:0] h2 [0:N_H2-1];
   logic signed [15:0] y  [0:N_SAMP-1];
   state_t             state;
   logic [3:0]         s, j, i, jm1;
   logic               busy, done;
   logic               aw_held, bvalid_r, rvalid_r;
   logic [7:0]         aw_idx, ar_idx, y_off;
   logic [DATA_W-1:0]  rd_word;
   logic               aw_hs, w_hs, ar_hs, store_en, start;
   logic               mac_en, mac_first;
   logic signed [15:0] mac_a, mac_b, mac_bias, mac_res;
   logic               unused_ok;

   assign unused_ok = ^{s_axi_awaddr[31:ADDR_W], s_axi_awaddr[1:0], s_axi_araddr[31:ADDR_W],
                        s_axi_araddr[1:0], s_axi_wstrb, s_axi_wdata[DATA_W-1:16]};

   assign s_axi_awready = !aw_held && !bvalid_r;
   assign s_axi_wready  = aw_held;
   assign s_axi_bvalid  = bvalid_r;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = !rvalid_r;
   assign s_axi_rvalid  = rvalid_r;
   assign s_axi_rresp   = 2'b00;

   assign aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_hs   = s_axi_wvalid && s_axi_wready;
   assign ar_hs  = s_axi_arvalid && s_axi_arready;
   assign ar_idx = s_axi_araddr[ADDR_W-1:2];
   assign y_off  = ar_idx - Y_IDX;
   assign jm1    = j - 4'd1;

   // Storage and start are gated by busy; the write is still acknowledged normally
   assign store_en = w_hs && !busy && aw_idx >= W1_IDX && aw_idx <= X_LAST_IDX;
   assign start    = w_hs && !busy &&
                     ((aw_idx == CTRL_IDX && s_axi_wdata[0]) || aw_idx == X_LAST_IDX);

   always_comb begin
      rd_word = '0;
      if (ar_idx == CTRL_IDX)
         rd_word = {30'b0, done, busy};
      else if (ar_idx >= Y_IDX && ar_idx <= Y_LAST_IDX)
         rd_word = {{16{y[y_off[3:0]][15]}}, y[y_off[3:0]]};
      else if (ar_idx >= W1_IDX && ar_idx < X_IDX)
         rd_word = {{16{mem[ar_idx][15]}}, mem[ar_idx]};
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_held     <= 1'b0;
         aw_idx      <= '0;
         bvalid_r    <= 1'b0;
         rvalid_r    <= 1'b0;
         s_axi_rdata <= '0;
      end else begin
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
         end else if (w_hs) begin
            aw_held <= 1'b0;
         end
         if (w_hs)              bvalid_r <= 1'b1;
         else if (s_axi_bready) bvalid_r <= 1'b0;
         if (ar_hs) begin
            rvalid_r    <= 1'b1;
            s_axi_rdata <= rd_word;
         end else if (s_axi_rready) begin
            rvalid_r    <= 1'b0;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = MEM_LO; k <= MEM_HI; k++) mem[k] <= '0;
      end else if (store_en) begin
         mem[aw_idx] <= s_axi_wdata[15:0];
      end
   end

   always_comb begin
      mac_en    = 1'b0;
      mac_first = (i == 4'd0);
      mac_a     = '0;
      mac_b     = '0;
      mac_bias  = '0;
      case (state)
         S_L1: begin
            mac_en   = 1'b1;
            mac_a    = mem[W1_IDX + {2'b0, j, 2'b0} + {4'b0, i}];
            mac_b    = mem[X_IDX + {4'b0, s} * 8'd3 + {4'b0, i}];
            mac_bias = mem[W1_IDX + {2'b0, j, 2'b0} + 8'd3];
         end
         S_L2: begin
            mac_en   = 1'b1;
            mac_a    = mem[W2_IDX + {4'b0, j} * 8'd12 + {4'b0, i}];
            mac_b    = h1[i];
         end
         S_L3: begin
            mac_en   = 1'b1;
            mac_a    = mem[W3_IDX + {4'b0, i}];
            mac_b    = h2[i[2:0]];
            mac_bias = mem[W3_BIAS_IDX];
         end
         default: ;
      endcase
   end

   dnn_mac u_mac (
      .clk   (aclk),
      .rst_n (aresetn),
      .en    (mac_en),
      .first (mac_first),
      .a     (mac_a),
      .b     (mac_b),
      .bias  (mac_bias),
      .res   (mac_res)
   );

   // A neuron's result is written back on the first MAC cycle of the following neuron
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= S_IDLE;
         s     <= '0;
         j     <= '0;
         i     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         for (int k = 0; k < N_H1; k++)   h1[k] <= '0;
         for (int k = 0; k < N_H2; k++)   h2[k] <= '0;
         for (int k = 0; k < N_SAMP; k++) y[k]  <= '0;
      end else if (start) begin
         state <= S_L1;
         s     <= '0;
         j     <= '0;
         i     <= '0;
         busy  <= 1'b1;
         done  <= 1'b0;
      end else begin
         case (state)
            S_L1: begin
               if (i == 4'd0 && j != 4'd0) h1[jm1] <= relu(mac_res);
               if (i == 4'(N_IN - 1)) begin
                  i <= '0;
                  if (j == 4'(N_H1 - 1)) begin
                     j     <= '0;
                     state <= S_L2;
                  end else j <= j + 4'd1;
               end else i <= i + 4'd1;
            end
            S_L2: begin
               if (i == 4'd0) begin
                  if (j == 4'd0) h1[N_H1-1]    <= relu(mac_res);
                  else           h2[jm1[2:0]] <= relu(mac_res);
               end
               if (i == 4'(N_H1 - 1)) begin
                  i <= '0;
                  if (j == 4'(N_H2 - 1)) begin
                     j     <= '0;
                     state <= S_L3;
                  end else j <= j + 4'd1;
               end else i <= i + 4'd1;
            end
            S_L3: begin
               if (i == 4'd0) h2[N_H2-1] <= relu(mac_res);
               if (i == 4'(N_H2 - 1)) begin
                  i     <= '0;
                  state <= S_STORE;
               end else i <= i + 4'd1;
            end
            S_STORE: begin
               y[s] <= mac_res;
               if (s == 4'(N_SAMP - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  s     <= s + 4'd1;
                  state <= S_L1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_dnn_slave.sv
// Directed bench for axi_dnn_slave: AXI-Lite writes/reads with a read scoreboard.
// Expected values are hand-derived Q5.10 results for small networks.
module tb_axi_dnn_slave;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] s_axi_awaddr = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = 4'hf;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b1;
   logic [31:0] s_axi_araddr = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b1;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];
   string       tag_q[$];

   always #5 aclk = ~aclk;

   axi_dnn_slave dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready)
   );

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      int n;
      s_axi_awaddr  = a;
      s_axi_awvalid = 1'b1;
      n = 0;
      while (!s_axi_awready && n < 50) begin tick(); n++; end
      check("aw_ready", {31'b0, s_axi_awready}, 32'd1);
      tick();
      s_axi_awvalid = 1'b0;
      s_axi_wdata   = d;
      s_axi_wvalid  = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin tick(); n++; end
      check("w_ready", {31'b0, s_axi_wready}, 32'd1);
      tick();
      s_axi_wvalid = 1'b0;
      n = 0;
      while (!s_axi_bvalid && n < 50) begin tick(); n++; end
      check("b_valid", {31'b0, s_axi_bvalid}, 32'd1);
      check("b_resp", {30'b0, s_axi_bresp}, 32'd0);
      tick();
   endtask

   task automatic rd_raw(input logic [31:0] a, output logic [31:0] d);
      int n;
      d = 'x;
      s_axi_araddr  = a;
      s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 50) begin tick(); n++; end
      tick();
      s_axi_arvalid = 1'b0;
      n = 0;
      while (!s_axi_rvalid && n < 50) begin tick(); n++; end
      if (s_axi_rvalid) d = s_axi_rdata;
      tick();
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      logic [31:0] got;
      sb_q.push_back(exp);
      tag_q.push_back(tag);
      rd_raw(a, got);
      check(tag_q.pop_front(), got, sb_q.pop_front());
   endtask

   task automatic wait_done(input string tag);
      int          n;
      logic [31:0] st;
      n = 0;
      do begin
         rd_raw(32'h000, st);
         n++;
      end while (st[1] !== 1'b1 && n < 1000);
      check(tag, {31'b0, st[1]}, 32'd1);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      repeat (3) tick();
      aresetn = 1'b1;
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) tick();
      check("rst_awready", {31'b0, s_axi_awready}, 32'd1);
      check("rst_arready", {31'b0, s_axi_arready}, 32'd1);
      check("rst_wready",  {31'b0, s_axi_wready},  32'd0);
      check("rst_bvalid",  {31'b0, s_axi_bvalid},  32'd0);
      check("rst_rvalid",  {31'b0, s_axi_rvalid},  32'd0);
      check("rst_rdata",   s_axi_rdata,            32'd0);
      aresetn = 1'b1;
      tick();
      rd(32'h000, 32'd0, "rst_status");

      wr(32'h010, 32'd512);
      check("b_single_pulse", {31'b0, s_axi_bvalid}, 32'd0);
      rd(32'h010, 32'd512, "w1_readback");

      // Identity path through neuron 0 of each layer
      wr(32'h010, 32'd1024);
      wr(32'h0D0, 32'd1024);
      wr(32'h1F0, 32'd1024);
      wr(32'h210, 32'd512);
      wr(32'h2CC, 32'd0);
      wait_done("done_ident");
      rd(32'h210, 32'd512, "y0_ident");
      rd(32'h214, 32'd0,   "y1_ident");
      rd(32'h000, 32'd2,   "status_done");

      wr(32'h010, 32'h0000_FC00);
      rd(32'h010, 32'hFFFF_FC00, "w1_sext");
      wr(32'h000, 32'd1);
      wait_done("done_relu");
      rd(32'h210, 32'd0, "y0_relu");

      wr(32'h010, 32'h0000_7FFF);
      wr(32'h210, 32'h0000_7FFF);
      wr(32'h000, 32'd1);
      rd(32'h000, 32'd1, "status_busy");
      wr(32'h0D0, 32'd0);
      wait_done("done_sat");
      rd(32'h210, 32'd32767, "y0_sat");
      rd(32'h214, 32'd0,     "y1_sat");
      rd(32'h0D0, 32'd1024,  "busy_write_ignored");

      wr(32'h0BF, 32'h0000_1234);
      rd(32'h0BC, 32'h0000_1234, "addr_lsb_ignored");
      wr(32'h20C, 32'h0000_8001);
      rd(32'h20C, 32'hFFFF_8001, "w3_spare");
      rd(32'h004, 32'd0, "ctrl_pad");
      rd(32'h250, 32'd0, "past_y");
      rd(32'h2CC, 32'd0, "x_write_only");
      rd(32'h3FC, 32'd0, "out_of_map");

      // Bias-only network: every sample yields the W3 bias
      do_reset();
      rd(32'h010, 32'd0, "w1_cleared");
      wr(32'h208, 32'd1024);
      wr(32'h000, 32'd1);
      wait_done("done_bias");
      for (int k = 0; k < 16; k++)
         rd(32'h210 + 32'(4 * k), 32'd1024, $sformatf("y%0d_bias", k));
      rd(32'h000, 32'd2, "status_done_bias");

      wr(32'h0BC, 32'd5);
      wr(32'h000, 32'd1);
      repeat (100) tick();
      rd(32'h000, 32'd1, "busy_mid_run");
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      tick();
      rd(32'h000, 32'd0, "abort_status");
      rd(32'h210, 32'd0, "abort_y0");
      rd(32'h208, 32'd0, "abort_w3_bias");
      rd(32'h0BC, 32'd0, "abort_w1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
